// File: rtl/m2_pkg.sv
// ---------------------------------------------------------------------------
// m2_pkg
//   Shared definitions for the Moore vending controller:
//     - state_t       : the four controller states
//     - DEF_*         : default values for the controller parameters
//     - cnt_width()   : width of a down-to-zero counter that must reach n-1
// ---------------------------------------------------------------------------
package m2_pkg;

  // Controller states. Two bits cover all four states exactly.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int DEF_PRICE       = 3;
  localparam int DEF_CNT_W       = 2;
  localparam int DEF_TIMEOUT     = 8;
  localparam int DEF_VEND_CYCLES = 2;

  // Bits needed for a counter running 0..n-1; never narrower than one bit
  // so that n = 1 or n = 2 still yields a legal vector.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/m2_edge_det.sv
// ---------------------------------------------------------------------------
// m2_edge_det
//   Rising-edge detector. Keeps a registered copy of d and flags the cycle
//   in which d is high while its copy from the previous cycle was low.
//
// Ports
//   clk  : clock, rising edge active
//   R    : synchronous active-high reset, clears the registered copy
//   d    : level input to watch
//   rise : high for the cycle in which d goes from 0 to 1
// ---------------------------------------------------------------------------
module m2_edge_det (
  input  logic clk,
  input  logic R,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle copy of d. Clearing it on reset means a level that is
  // already high when reset releases is reported as a fresh edge once.
  always_ff @(posedge clk) begin
    if (R) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/m2_moore_vend.sv
// ---------------------------------------------------------------------------
// m2_moore_vend
//   Moore-style vending controller. A transaction starts on iT, collects
//   coin edges on iM until PRICE is reached (vend for VEND_CYCLES cycles),
//   or ends in a one-cycle refund on cancel (iC) or after TIMEOUT idle
//   cycles without a coin. All outputs come straight from registers.
//
// Parameters
//   PRICE       : coin events needed to vend, 1..2**CNT_W-1
//   CNT_W       : width of the coin counter and of D
//   TIMEOUT     : coin-free COLLECT cycles before refund, >= 2
//   VEND_CYCLES : cycles that V is held high, >= 1
//
// Ports
//   clk : clock, rising edge active
//   R   : synchronous active-high reset
//   iT  : start-transaction request (level)
//   iM  : coin input, one event per rising edge
//   iC  : cancel request (level)
//   T   : transaction active
//   V   : vend
//   F   : refund
//   D   : coins accepted in the current transaction
// ---------------------------------------------------------------------------
module m2_moore_vend
  import m2_pkg::*;
#(
  parameter int PRICE       = DEF_PRICE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int VEND_CYCLES = DEF_VEND_CYCLES
) (
  input  logic             clk,
  input  logic             R,
  input  logic             iT,
  input  logic             iM,
  input  logic             iC,
  output logic             T,
  output logic             V,
  output logic             F,
  output logic [CNT_W-1:0] D
);

  localparam int TO_W = cnt_width(TIMEOUT);
  localparam int VC_W = cnt_width(VEND_CYCLES);

  localparam logic [CNT_W-1:0] PRICE_C = CNT_W'(PRICE);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [VC_W-1:0]  VC_LAST = VC_W'(VEND_CYCLES - 1);

  // Refuse to build with a parameter set the counters cannot represent.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("m2_moore_vend: CNT_W must be at least 1");
  end
  if (PRICE < 1 || PRICE > (2 ** CNT_W) - 1) begin : g_bad_price
    $error("m2_moore_vend: PRICE must lie in 1..2**CNT_W-1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("m2_moore_vend: TIMEOUT must be at least 2");
  end
  if (VEND_CYCLES < 1) begin : g_bad_vend_cycles
    $error("m2_moore_vend: VEND_CYCLES must be at least 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] count_inc;
  logic [TO_W-1:0]  tmo;
  logic [TO_W-1:0]  tmo_nxt;
  logic [VC_W-1:0]  vcnt;
  logic [VC_W-1:0]  vcnt_nxt;
  logic             coin;
  logic             t_q;
  logic             v_q;
  logic             f_q;

  // A held coin line produces a single event; the detector owns the
  // registered copy of iM so reset clears it along with everything else.
  m2_edge_det u_coin_edge (
    .clk  (clk),
    .R    (R),
    .d    (iM),
    .rise (coin)
  );

  // count never reaches PRICE while collecting, so this cannot wrap.
  assign count_inc = count + CNT_W'(1);

  // Next-state and next-counter logic. In COLLECT the order of the if-chain
  // is the priority: cancel beats a coin arriving in the same cycle, a coin
  // that completes the price beats the timeout, and only a coin-free cycle
  // advances the timeout counter.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tmo_nxt   = tmo;
    vcnt_nxt  = vcnt;
    case (state)
      IDLE: begin
        count_nxt = '0;
        tmo_nxt   = '0;
        vcnt_nxt  = '0;
        if (iT) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (iC) begin
          state_nxt = REFUND;
        end else if (coin) begin
          tmo_nxt   = '0;
          count_nxt = count_inc;
          if (count_inc == PRICE_C) begin
            state_nxt = VEND;
            vcnt_nxt  = '0;
          end
        end else if (tmo == TO_LAST) begin
          state_nxt = REFUND;
        end else begin
          tmo_nxt = tmo + TO_W'(1);
        end
      end
      VEND: begin
        if (vcnt == VC_LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
          vcnt_nxt  = '0;
        end else begin
          vcnt_nxt = vcnt + VC_W'(1);
        end
      end
      REFUND: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        tmo_nxt   = '0;
        vcnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and the T/V/F flags all update on the same edge. The
  // flags are decoded from the next state so they line up with the state
  // register and drive the outputs with no logic behind them.
  always_ff @(posedge clk) begin
    if (R) begin
      state <= IDLE;
      count <= '0;
      tmo   <= '0;
      vcnt  <= '0;
      t_q   <= 1'b0;
      v_q   <= 1'b0;
      f_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tmo   <= tmo_nxt;
      vcnt  <= vcnt_nxt;
      t_q   <= (state_nxt != IDLE);
      v_q   <= (state_nxt == VEND);
      f_q   <= (state_nxt == REFUND);
    end
  end

  assign T = t_q;
  assign V = v_q;
  assign F = f_q;
  assign D = count;

endmodule

// File: doc/m2_moore_vend.md
M2_MOORE_VEND -- requirements
Module: m2_moore_vend

Interface
REQ-001 The block SHALL have parameter PRICE, default 3: number of coin events required to vend; legal range 1..2**CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 2: width of the coin counter and of D.
REQ-003 The block SHALL have parameter TIMEOUT, default 8: idle cycles in COLLECT before automatic refund; must be at least 2.
REQ-004 The block SHALL have parameter VEND_CYCLES, default 2: number of cycles V is held; must be at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 The block SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port iT, input, 1 bit: start-transaction request, level-sampled.
REQ-008 The block SHALL have port iM, input, 1 bit: coin input; one coin event per rising edge.
REQ-009 The block SHALL have port iC, input, 1 bit: cancel request, level-sampled.
REQ-010 The block SHALL have port T, output, 1 bit: transaction active.
REQ-011 The block SHALL have port V, output, 1 bit: vend.
REQ-012 The block SHALL have port F, output, 1 bit: refund.
REQ-013 The block SHALL have port D, output, CNT_W bits: coins accepted in the current transaction.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, COLLECT, VEND, REFUND.
REQ-015 All outputs SHALL be Moore outputs, taken from the state register and the coin-count register only, with no combinational path from any input.
REQ-016 A coin event SHALL be iM=1 in the current cycle with iM=0 in the previous cycle, using a registered copy of iM; a held iM SHALL count once.
REQ-017 In IDLE, outputs SHALL be T=0, V=0, F=0, D=0, and iT=1 SHALL move to COLLECT next cycle; otherwise the block stays in IDLE.
REQ-018 A coin event in IDLE SHALL be ignored, with D remaining 0.
REQ-019 In COLLECT, outputs SHALL be T=1, V=0, F=0, D=count.
REQ-020 On a coin event in COLLECT, D SHALL become D+1 at the next edge, a one-cycle latency.
REQ-021 When D+1 equals PRICE in COLLECT, the next state SHALL be VEND with D=PRICE.
REQ-022 iC=1 in COLLECT SHALL move to REFUND next cycle, and cancel SHALL take priority over a simultaneous coin event, which is discarded so D is not incremented.
REQ-023 A timeout counter SHALL clear on entry to COLLECT and on every coin event, and SHALL increment on every other COLLECT cycle.
REQ-024 When the timeout counter equals TIMEOUT-1 with no coin event and no cancel, the next state SHALL be REFUND.
REQ-025 Priority in COLLECT SHALL be cancel, then PRICE reached, then timeout, then stay.
REQ-026 In VEND, outputs SHALL be T=1, V=1, F=0, D=PRICE for exactly VEND_CYCLES cycles, after which the state returns to IDLE and D clears to 0.
REQ-027 iM, iT and iC SHALL be ignored in VEND.
REQ-028 In REFUND, outputs SHALL be T=1, V=0, F=1, with D holding the coin count at cancel or timeout, for exactly one cycle, then IDLE with D=0.
REQ-029 iM, iT and iC SHALL be ignored in REFUND.
REQ-030 With PRICE=1, the first coin event in COLLECT SHALL go directly to VEND.
REQ-031 D SHALL never exceed PRICE and SHALL never wrap.
REQ-032 Encoding SHALL use enough state bits for four states, and any unreachable encoding SHALL return to IDLE with all outputs 0.
REQ-033 Illegal parameter combinations SHALL be rejected at elaboration by an assertion.

Reset
REQ-034 R=1 at a rising edge SHALL force state=IDLE, D=0, timeout counter 0, VEND cycle counter 0, registered iM copy 0, and therefore T=V=F=0 on the following cycle.
REQ-035 Reset SHALL override every state and input, including mid-VEND and mid-REFUND, with no V or F pulse completing after R.
REQ-036 A coin held high across reset release SHALL not count, because the registered iM copy is 0 only for the first cycle after release; if iM is still 1 in that cycle, an edge is seen, but the block is in IDLE and the coin is ignored.

Structure
REQ-037 The state typedef SHALL be defined in shared package m2_pkg, along with default parameter constants.
REQ-038 Rising-edge detection SHALL be a sub-module m2_edge_det with ports clk, R, d and rise, reset to 0.
REQ-039 The block SHALL contain no latches, and every always_comb SHALL assign defaults.

Verification
REQ-040 With PRICE=3, the bench SHALL apply reset, iT=1 for 1 cycle, then 3 separate iM pulses, and check D steps 0->1->2, then VEND with V=1 and D=3 for 2 cycles, then IDLE with D=0.
REQ-041 The bench SHALL hold iM=1 for 5 cycles in COLLECT and check D=1 only.
REQ-042 The bench SHALL drive 1 coin then iC=1 simultaneous with a second coin edge, and check a REFUND cycle with F=1 and D=1, then IDLE.
REQ-043 With TIMEOUT=8, the bench SHALL drive 1 coin then no activity, and check REFUND exactly 8 cycles after the coin-registered cycle, with F=1 and D=1.
REQ-044 The bench SHALL assert R=1 in the first VEND cycle and check V=0, T=0, D=0 on the next cycle and no further V.
REQ-045 With PRICE=1, the bench SHALL drive iT then one coin and check VEND immediately with D=1.
